// File: rtl/gpio_in_conditioner.sv
// 16-bit GPIO input conditioner: two-flop synchronizer, per-bit debounce,
// parity, sticky edge flags and an OR-reduced interrupt request.
module gpio_in_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [15:0] PAD_IN,
    input  logic        EN,
    input  logic        PARITYSEL,
    input  logic [15:0] RISE_EN,
    input  logic [15:0] FALL_EN,
    input  logic [15:0] IRQ_CLR,
    output logic [16:0] GPIOIN,
    output logic [15:0] EDGE_STATUS,
    output logic        IRQ
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [15:0] sync1;
    logic [15:0] sync2;
    logic [15:0] db;
    logic [7:0]  cnt [16];
    logic [15:0] accept;
    logic [15:0] edge_set;

    // A bit is accepted on the edge its counter is already at its last value.
    always_comb begin
        // NOTE: every bit gets a default before the loop so no latch is inferred.
        accept = '0;
        for (int i = 0; i < 16; i++) begin
            accept[i] = EN && (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
        end
        edge_set = accept & ((sync2 & RISE_EN) | (~sync2 & FALL_EN));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync1       <= '0;
            sync2       <= '0;
            db          <= '0;
            EDGE_STATUS <= '0;
            // NOTE: the counter array is reset element by element; a partial count must not survive reset.
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= PAD_IN;
            sync2 <= sync1;
            for (int i = 0; i < 16; i++) begin
                if (!EN || (sync2[i] == db[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
                if (accept[i]) begin
                    db[i] <= sync2[i];
                end
            end
            // A set on the same edge as a clear wins.
            EDGE_STATUS <= (EDGE_STATUS & ~IRQ_CLR) | edge_set;
        end
    end

    assign GPIOIN = {(^db) ^ PARITYSEL, db};
    assign IRQ    = |EDGE_STATUS;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: a vector table for the main
// debounce/edge/parity behaviour plus directed multi-cycle sequences.
module tb_gpio_in_conditioner;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [15:0] PAD_IN;
    logic        EN;
    logic        PARITYSEL;
    logic [15:0] RISE_EN;
    logic [15:0] FALL_EN;
    logic [15:0] IRQ_CLR;
    logic [16:0] gpioin;
    logic [15:0] edge_status;
    logic        irq;
    logic [16:0] gpioin1;
    logic [15:0] edge_status1;
    logic        irq1;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    gpio_in_conditioner dut (
        .HCLK(HCLK), .HRESET(HRESET), .PAD_IN(PAD_IN), .EN(EN),
        .PARITYSEL(PARITYSEL), .RISE_EN(RISE_EN), .FALL_EN(FALL_EN),
        .IRQ_CLR(IRQ_CLR), .GPIOIN(gpioin), .EDGE_STATUS(edge_status), .IRQ(irq)
    );

    gpio_in_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .PAD_IN(PAD_IN), .EN(EN),
        .PARITYSEL(PARITYSEL), .RISE_EN(RISE_EN), .FALL_EN(FALL_EN),
        .IRQ_CLR(IRQ_CLR), .GPIOIN(gpioin1), .EDGE_STATUS(edge_status1), .IRQ(irq1)
    );

    typedef struct {
        logic [15:0] pad;
        logic        en;
        logic        ps;
        logic [15:0] rise_en;
        logic [15:0] fall_en;
        logic [15:0] irq_clr;
        logic [16:0] exp_gpioin;
        logic [15:0] exp_status;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [15:0] pad, input logic ps, input logic [15:0] rise_en,
                       input logic [15:0] irq_clr, input logic [16:0] exp_gpioin,
                       input logic [15:0] exp_status, input logic exp_irq);
        vec_t v;
        v.pad        = pad;
        v.en         = 1'b1;
        v.ps         = ps;
        v.rise_en    = rise_en;
        v.fall_en    = 16'hFFFF;
        v.irq_clr    = irq_clr;
        v.exp_gpioin = exp_gpioin;
        v.exp_status = exp_status;
        v.exp_irq    = exp_irq;
        vecs.push_back(v);
    endtask

    // One clock: inputs already driven at a falling edge, sample at the next one.
    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic do_reset(input logic en, input logic ps, input logic [15:0] pad);
        @(negedge HCLK);
        HRESET    = 1'b1;
        EN        = en;
        PARITYSEL = ps;
        PAD_IN    = pad;
        RISE_EN   = 16'hFFFF;
        FALL_EN   = 16'hFFFF;
        IRQ_CLR   = 16'h0000;
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET    = 1'b1;
        PAD_IN    = 16'h0000;
        EN        = 1'b1;
        PARITYSEL = 1'b0;
        RISE_EN   = 16'hFFFF;
        FALL_EN   = 16'hFFFF;
        IRQ_CLR   = 16'h0000;

        // Glitch on bit 3 held for three cycles: rejected.
        for (int i = 0; i < 3; i++) add(16'h0008, 1'b0, 16'hFFFF, 16'h0000, 17'h00000, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) add(16'h0000, 1'b0, 16'hFFFF, 16'h0000, 17'h00000, 16'h0000, 1'b0);
        // Step on bit 0: accepted on the sixth edge.
        for (int i = 0; i < 5; i++) add(16'h0001, 1'b0, 16'hFFFF, 16'h0000, 17'h00000, 16'h0000, 1'b0);
        add(16'h0001, 1'b0, 16'hFFFF, 16'h0000, 17'h10001, 16'h0001, 1'b1);
        add(16'h0001, 1'b1, 16'hFFFF, 16'h0000, 17'h00001, 16'h0001, 1'b1);
        // Bit 0 falls; the clear coinciding with the new falling edge loses.
        for (int i = 0; i < 5; i++) add(16'h0000, 1'b0, 16'hFFFF, 16'h0000, 17'h10001, 16'h0001, 1'b1);
        add(16'h0000, 1'b0, 16'hFFFF, 16'h0001, 17'h00000, 16'h0001, 1'b1);
        add(16'h0000, 1'b0, 16'hFFFF, 16'h0001, 17'h00000, 16'h0000, 1'b0);
        add(16'h0000, 1'b1, 16'hFFFF, 16'h0000, 17'h10000, 16'h0000, 1'b0);
        // Bits 8 and 9 rise together; only bit 8 has rise capture enabled.
        for (int i = 0; i < 5; i++) add(16'h0300, 1'b0, 16'h0100, 16'h0000, 17'h00000, 16'h0000, 1'b0);
        add(16'h0300, 1'b0, 16'h0100, 16'h0000, 17'h00300, 16'h0100, 1'b1);
        add(16'h0300, 1'b0, 16'h0000, 16'h0000, 17'h00300, 16'h0100, 1'b1);

        @(negedge HCLK);
        check("reset_gpioin", 32'(gpioin), 32'h00000);
        check("reset_status", 32'(edge_status), 32'h0000);
        check("reset_irq", 32'(irq), 32'h0);
        HRESET = 1'b0;

        foreach (vecs[n]) begin
            PAD_IN    = vecs[n].pad;
            EN        = vecs[n].en;
            PARITYSEL = vecs[n].ps;
            RISE_EN   = vecs[n].rise_en;
            FALL_EN   = vecs[n].fall_en;
            IRQ_CLR   = vecs[n].irq_clr;
            step();
            check($sformatf("vec%0d_gpioin", n), 32'(gpioin), 32'(vecs[n].exp_gpioin));
            check($sformatf("vec%0d_status", n), 32'(edge_status), 32'(vecs[n].exp_status));
            check($sformatf("vec%0d_irq", n), 32'(irq), 32'(vecs[n].exp_irq));
        end

        // Mid-debounce reset: bit 5 reaches cnt=2, then reset discards it.
        PAD_IN  = 16'h0320;
        RISE_EN = 16'hFFFF;
        IRQ_CLR = 16'h0000;
        for (int i = 0; i < 4; i++) step();
        check("midrst_pre_gpioin", 32'(gpioin), 32'h00300);
        check("midrst_pre_status", 32'(edge_status), 32'h0100);
        PARITYSEL = 1'b1;
        #2 HRESET = 1'b1;
        #1;
        check("midrst_gpioin", 32'(gpioin), 32'h10000);
        check("midrst_status", 32'(edge_status), 32'h0000);
        check("midrst_irq", 32'(irq), 32'h0);
        @(negedge HCLK);
        HRESET    = 1'b0;
        PARITYSEL = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("midrst_wait%0d", i), 32'(gpioin), 32'h00000);
        end
        step();
        check("midrst_accept_gpioin", 32'(gpioin), 32'h10320);
        check("midrst_accept_status", 32'(edge_status), 32'h0320);
        check("midrst_accept_irq", 32'(irq), 32'h1);

        // Enable hold: pad high with EN low never reaches db.
        do_reset(1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("hold%0d", i), 32'(gpioin), 32'h10000);
        end
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_en%0d", i), 32'(gpioin), 32'h10000);
        end
        step();
        check("hold_accept_gpioin", 32'(gpioin), 32'h1FFFF);
        check("hold_accept_status", 32'(edge_status), 32'hFFFF);
        check("hold_accept_irq", 32'(irq), 32'h1);

        // Single-cycle debounce instance.
        do_reset(1'b1, 1'b0, 16'h0000);
        PAD_IN = 16'h0001;
        step();
        step();
        check("d1_step_wait", 32'(gpioin1), 32'h00000);
        step();
        check("d1_step_accept", 32'(gpioin1), 32'h10001);
        check("d1_step_status", 32'(edge_status1), 32'h0001);
        PAD_IN = 16'h0003;
        step();
        PAD_IN = 16'h0001;
        step();
        check("d1_pulse_wait", 32'(gpioin1), 32'h10001);
        step();
        check("d1_pulse_accept", 32'(gpioin1), 32'h00003);
        step();
        check("d1_pulse_return", 32'(gpioin1), 32'h10001);
        check("d4_pulse_rejected", 32'(gpioin), 32'h10001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
